// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, register-count derivation and the busy-vector
// popcount helpers used to keep pend_cnt in step with the scoreboard.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 4;

   // Widest address the popcount helpers cover; ADDR_W must not exceed it.
   localparam int MAX_ADDR_W = 8;
   localparam int MAX_REGS   = 2**MAX_ADDR_W;

   // Number of architectural registers for a given address width.
   function automatic int num_regs(input int addr_w);
      return 2**addr_w;
   endfunction

   // Busy bits that rose and fell across one edge.
   typedef struct packed {
      int n_set;
      int n_clr;
   } busy_delta_t;

   // Popcount of the 0->1 and 1->0 transitions between two busy vectors.
   function automatic busy_delta_t busy_delta(input logic [MAX_REGS-1:0] busy_q,
                                              input logic [MAX_REGS-1:0] busy_d);
      busy_delta_t d;
      d.n_set = 0;
      d.n_clr = 0;
      for (int i = 0; i < MAX_REGS; i++) begin
         d.n_set += int'(busy_d[i] & ~busy_q[i]);
         d.n_clr += int'(busy_q[i] & ~busy_d[i]);
      end
      return d;
   endfunction

   // Next pending count: current count plus rises minus falls. Because it
   // tracks real transitions of the busy vector it can never wrap.
   function automatic int pend_next(input int                  cnt,
                                    input logic [MAX_REGS-1:0] busy_q,
                                    input logic [MAX_REGS-1:0] busy_d);
      busy_delta_t d;
      d = busy_delta(busy_q, busy_d);
      return cnt + d.n_set - d.n_clr;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, pending-producer count and the
// sticky double-reserve flag. A reserve marks a register busy; any write to
// it clears the bit, except that a same-cycle reserve wins.
import regfile_pkg::*;

module regfile_scoreboard #(
   parameter  int ADDR_W   = ADDR_W_DEF,
   parameter  int CNT_W    = ADDR_W + 1,
   localparam int NUM_REGS = num_regs(ADDR_W)
) (
   input  logic                clk,
   input  logic                i_clr,
   input  logic                i_rsv_en,
   input  logic [ADDR_W-1:0]   i_rsv_addr,
   input  logic                i_we0,
   input  logic [ADDR_W-1:0]   i_wa0,
   input  logic                i_we1,
   input  logic [ADDR_W-1:0]   i_wa1,
   output logic [NUM_REGS-1:0] o_busy,
   output logic [CNT_W-1:0]    o_pend_cnt,
   output logic                o_err_dbl_rsv
);

   logic [NUM_REGS-1:0] r_busy;
   logic [CNT_W-1:0]    r_pend_cnt;
   logic                r_err_dbl_rsv;

   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic                w_dbl_rsv;

   // Build the reserve/write masks and the next busy vector (reserve wins).
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_rsv_en) w_set_mask[i_rsv_addr] = 1'b1;
      if (i_we0)    w_clr_mask[i_wa0]      = 1'b1;
      if (i_we1)    w_clr_mask[i_wa1]      = 1'b1;
      w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
      w_dbl_rsv  = i_rsv_en && r_busy[i_rsv_addr] && !w_clr_mask[i_rsv_addr];
   end

   // Scoreboard state update with synchronous clear.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (i_clr) begin
         r_busy        <= '0;
         r_pend_cnt    <= '0;
         r_err_dbl_rsv <= 1'b0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_pend_cnt <= CNT_W'(pend_next(int'(r_pend_cnt),
                                        MAX_REGS'(r_busy),
                                        MAX_REGS'(w_busy_nxt)));
         if (w_dbl_rsv) r_err_dbl_rsv <= 1'b1;
      end
   end

   assign o_busy        = r_busy;
   assign o_pend_cnt    = r_pend_cnt;
   assign o_err_dbl_rsv = r_err_dbl_rsv;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 2-write register file with a busy scoreboard for RAW
// hazard detection. Write port 1 has priority over port 0 on the same address.
// Optional macro REGFILE_BYPASS_EN adds combinational write-to-read forwarding;
// without it the read outputs reflect registered state only.
import regfile_pkg::*;

module regfile_sb #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              we0,
   input  logic [ADDR_W-1:0] wa0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] wa1,
   input  logic [DATA_W-1:0] wd1,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [CNT_W-1:0]  pend_cnt,
   output logic              err_dbl_rsv
);

   localparam int NUM_REGS = num_regs(ADDR_W);

   logic [DATA_W-1:0]   r_mem [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy;

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_scoreboard (
      .clk           (clk),
      .i_clr         (clr),
      .i_rsv_en      (rsv_en),
      .i_rsv_addr    (rsv_addr),
      .i_we0         (we0),
      .i_wa0         (wa0),
      .i_we1         (we1),
      .i_wa1         (wa1),
      .o_busy        (w_busy),
      .o_pend_cnt    (pend_cnt),
      .o_err_dbl_rsv (err_dbl_rsv)
   );

   // Data array: clear on clr, else port 0 then port 1 so port 1 wins a tie.
   always_ff @(posedge clk) begin
      if (clr) begin
         // NOTE: the array is cleared on reset because reads after clr must return 0; this keeps it out of block RAM.
         for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      end else begin
         if (we0) r_mem[wa0] <= wd0;
         if (we1) r_mem[wa1] <= wd1;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Read muxes with same-cycle forwarding; everything reads 0 during clr.
   always_comb begin
      A      = '0;
      B      = '0;
      busy_a = 1'b0;
      busy_b = 1'b0;
      if (!clr) begin
         if (we1 && wa1 == ra)      A = wd1;
         else if (we0 && wa0 == ra) A = wd0;
         else                       A = r_mem[ra];
         if (we1 && wa1 == rb)      B = wd1;
         else if (we0 && wa0 == rb) B = wd0;
         else                       B = r_mem[rb];
         busy_a = w_busy[ra] && !((we0 && wa0 == ra) || (we1 && wa1 == ra));
         busy_b = w_busy[rb] && !((we0 && wa0 == rb) || (we1 && wa1 == rb));
      end
   end
`else
   // Read muxes from registered state only.
   always_comb begin
      A      = r_mem[ra];
      B      = r_mem[rb];
      busy_a = w_busy[ra];
      busy_b = w_busy[rb];
   end
`endif

endmodule
